// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM sequencing a multicycle MIPS datapath with a single shared
//   instruction/data memory, one ALU and a register file. It drives every
//   mux select and write enable of the datapath each cycle from OP/FUNCT/ZERO.
//   It stalls on MEM_READY and traps on illegal opcodes or R-type functs.
// Ports
//   CLK, RST             clock (posedge), synchronous active-high reset
//   OP, FUNCT            instruction fields from the instruction register
//   ZERO                 ALU zero flag (used only in BEQEX)
//   MEM_READY            shared memory completes its access this cycle
//   IORD .. PCSRC        datapath mux selects and write enables
//   PC_EN                PC load = PCWRITE | (BRANCH & ZERO)
//   RETIRE               one-cycle pulse when an instruction completes
//   HALTED               high while trapped on an illegal instruction
//   STATE                current state encoding (debug)
module multicycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OP,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       IORD,
  output logic       MEMWRITE,
  output logic       IRWRITE,
  output logic       REGDST,
  output logic       MEM2REG,
  output logic       REGWRITE,
  output logic       ALUSRCA,
  output logic [1:0] ALUSRCB,
  output logic [2:0] ALU_CONTROL,
  output logic [1:0] PCSRC,
  output logic       PC_EN,
  output logic       RETIRE,
  output logic       HALTED,
  output logic [3:0] STATE
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pcwrite;
  logic       branch;

  // R-type funct decode, shared by the ALU select and the trap transition.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (FUNCT)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (MEM_READY) state_next = S_DECODE;
      S_DECODE: begin
        if (OP == OP_LW || OP == OP_SW) state_next = S_MEMADR;
        else if (OP == OP_RTYPE)        state_next = S_RTYPEEX;
        else if (OP == OP_BEQ)          state_next = S_BEQEX;
        else if (OP == OP_ADDI)         state_next = S_ADDIEX;
        else if (OP == OP_J)            state_next = S_JEX;
        else                            state_next = S_TRAP;
      end
      S_MEMADR:  state_next = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (MEM_READY) state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   if (MEM_READY) state_next = S_FETCH;
      S_RTYPEEX: state_next = funct_ok ? S_RTYPEWB : S_TRAP;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JEX:     state_next = S_FETCH;
      S_TRAP:    state_next = S_TRAP;
      default:   state_next = S_FETCH;
    endcase
  end

  // Outputs are gated by RST so nothing is enabled during reset, even
  // before the state register has been initialised.
  always_comb begin
    IORD        = 1'b0;
    MEMWRITE    = 1'b0;
    IRWRITE     = 1'b0;
    REGDST      = 1'b0;
    MEM2REG     = 1'b0;
    REGWRITE    = 1'b0;
    ALUSRCA     = 1'b0;
    ALUSRCB     = 2'b00;
    ALU_CONTROL = 3'b000;
    PCSRC       = 2'b00;
    RETIRE      = 1'b0;
    HALTED      = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    if (!RST) begin
      case (state)
        S_FETCH: begin
          ALUSRCB     = 2'b01;
          ALU_CONTROL = ALU_ADD;
          IRWRITE     = MEM_READY;
          pcwrite     = MEM_READY;
        end
        S_DECODE: begin
          ALUSRCB     = 2'b11;
          ALU_CONTROL = ALU_ADD;
        end
        S_MEMADR: begin
          ALUSRCA     = 1'b1;
          ALUSRCB     = 2'b10;
          ALU_CONTROL = ALU_ADD;
        end
        S_MEMRD: IORD = 1'b1;
        S_MEMWB: begin
          MEM2REG  = 1'b1;
          REGWRITE = 1'b1;
          RETIRE   = 1'b1;
        end
        S_MEMWR: begin
          IORD     = 1'b1;
          MEMWRITE = 1'b1;
          RETIRE   = MEM_READY;
        end
        S_RTYPEEX: begin
          ALUSRCA     = 1'b1;
          ALU_CONTROL = funct_alu;
        end
        S_RTYPEWB: begin
          REGDST   = 1'b1;
          REGWRITE = 1'b1;
          RETIRE   = 1'b1;
        end
        S_BEQEX: begin
          ALUSRCA     = 1'b1;
          ALU_CONTROL = ALU_SUB;
          PCSRC       = 2'b01;
          branch      = 1'b1;
          RETIRE      = 1'b1;
        end
        S_ADDIEX: begin
          ALUSRCA     = 1'b1;
          ALUSRCB     = 2'b10;
          ALU_CONTROL = ALU_ADD;
        end
        S_ADDIWB: begin
          REGWRITE = 1'b1;
          RETIRE   = 1'b1;
        end
        S_JEX: begin
          PCSRC   = 2'b10;
          pcwrite = 1'b1;
          RETIRE  = 1'b1;
        end
        S_TRAP:  HALTED = 1'b1;
        default: ;
      endcase
    end
  end

  assign PC_EN = pcwrite | (branch & ZERO);
  assign STATE = RST ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed, table-driven bench for multicycle_controller. Each table row
//   gives the inputs for one cycle plus the expected STATE and the expected
//   packed output bundle in that cycle. A second phase measures per-opcode
//   latency and retire counts.
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OP = 6'h00;
  logic [5:0] FUNCT = 6'h00;
  logic       ZERO = 1'b0;
  logic       MEM_READY = 1'b1;
  logic       IORD, MEMWRITE, IRWRITE, REGDST, MEM2REG, REGWRITE, ALUSRCA;
  logic [1:0] ALUSRCB, PCSRC;
  logic [2:0] ALU_CONTROL;
  logic       PC_EN, RETIRE, HALTED;
  logic [3:0] STATE;

  multicycle_controller dut (
    .CLK(CLK), .RST(RST), .OP(OP), .FUNCT(FUNCT), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .IORD(IORD), .MEMWRITE(MEMWRITE),
    .IRWRITE(IRWRITE), .REGDST(REGDST), .MEM2REG(MEM2REG),
    .REGWRITE(REGWRITE), .ALUSRCA(ALUSRCA), .ALUSRCB(ALUSRCB),
    .ALU_CONTROL(ALU_CONTROL), .PCSRC(PCSRC), .PC_EN(PC_EN),
    .RETIRE(RETIRE), .HALTED(HALTED), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ready;
    logic [3:0]  exp_state;
    logic [16:0] exp_out;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Bundle order: IORD MEMWRITE IRWRITE REGDST MEM2REG REGWRITE ALUSRCA
  //               ALUSRCB[1:0] ALU_CONTROL[2:0] PCSRC[1:0] PC_EN RETIRE HALTED
  function automatic logic [16:0] mk(logic iord, logic mw, logic irw, logic rd,
                                     logic m2r, logic rw, logic sa, logic [1:0] sb,
                                     logic [2:0] alu, logic [1:0] ps, logic pce,
                                     logic ret, logic hlt);
    return {iord, mw, irw, rd, m2r, rw, sa, sb, alu, ps, pce, ret, hlt};
  endfunction

  function automatic logic [16:0] outs();
    return {IORD, MEMWRITE, IRWRITE, REGDST, MEM2REG, REGWRITE, ALUSRCA,
            ALUSRCB, ALU_CONTROL, PCSRC, PC_EN, RETIRE, HALTED};
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input string name, input logic rst, input logic [5:0] op,
                     input logic [5:0] funct, input logic zero, input logic ready,
                     input logic [3:0] st, input logic [16:0] o);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.funct = funct; v.zero = zero;
    v.ready = ready; v.exp_state = st; v.exp_out = o;
    vecs.push_back(v);
  endtask

  task automatic measure(input string name, input logic [5:0] op,
                         input logic [5:0] funct, input int unsigned exp_cycles);
    int unsigned cyc = 0;
    int unsigned ret = 0;
    @(negedge CLK);
    RST = 1'b1; MEM_READY = 1'b1; ZERO = 1'b0; OP = op; FUNCT = funct;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk({name, "_start"}, STATE, 0);
    while (1) begin
      ret += RETIRE;
      @(negedge CLK);
      #1;
      cyc++;
      if (STATE == 4'd0 || cyc >= 20) break;
    end
    chk({name, "_cycles"}, cyc, exp_cycles);
    chk({name, "_retires"}, ret, 1);
  endtask

  logic [16:0] O_ZERO, O_FETCH, O_FSTALL, O_DEC, O_MADR, O_MRD, O_MWB;
  logic [16:0] O_MWR, O_MWRS, O_REX_SLT, O_REX_BAD, O_RWB, O_BEQ1, O_BEQ0;
  logic [16:0] O_AEX, O_AWB, O_JEX, O_TRAP;

  initial begin
    O_ZERO    = '0;
    O_FETCH   = mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,0);
    O_FSTALL  = mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,0);
    O_DEC     = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,0);
    O_MADR    = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
    O_MRD     = mk(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
    O_MWB     = mk(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1,0);
    O_MWR     = mk(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,1,0);
    O_MWRS    = mk(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
    O_REX_SLT = mk(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0,0);
    O_REX_BAD = mk(0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0,0,0);
    O_RWB     = mk(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1,0);
    O_BEQ1    = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,1,0);
    O_BEQ0    = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1,0);
    O_AEX     = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
    O_AWB     = mk(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0);
    O_JEX     = mk(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,1,0);
    O_TRAP    = mk(0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,1);

    // reset, then LW with MEM_READY=1
    add("rst0",   1, 6'h23, 6'h00, 0, 1, 4'd0, O_ZERO);
    add("rst1",   1, 6'h23, 6'h00, 0, 1, 4'd0, O_ZERO);
    add("lw_f",   0, 6'h23, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("lw_d",   0, 6'h23, 6'h00, 0, 1, 4'd1, O_DEC);
    add("lw_a",   0, 6'h23, 6'h00, 0, 1, 4'd2, O_MADR);
    add("lw_r",   0, 6'h23, 6'h00, 0, 1, 4'd3, O_MRD);
    add("lw_wb",  0, 6'h23, 6'h00, 0, 1, 4'd4, O_MWB);
    // R-type slt, preceded by a one-cycle fetch stall
    add("r_fst",  0, 6'h00, 6'h2A, 1, 0, 4'd0, O_FSTALL);
    add("r_f",    0, 6'h00, 6'h2A, 1, 1, 4'd0, O_FETCH);
    add("r_d",    0, 6'h00, 6'h2A, 1, 1, 4'd1, O_DEC);
    add("r_ex",   0, 6'h00, 6'h2A, 1, 1, 4'd6, O_REX_SLT);
    add("r_wb",   0, 6'h00, 6'h2A, 1, 1, 4'd7, O_RWB);
    // BEQ taken then not taken
    add("b1_f",   0, 6'h04, 6'h00, 1, 1, 4'd0, O_FETCH);
    add("b1_d",   0, 6'h04, 6'h00, 1, 1, 4'd1, O_DEC);
    add("b1_ex",  0, 6'h04, 6'h00, 1, 1, 4'd8, O_BEQ1);
    add("b0_f",   0, 6'h04, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("b0_d",   0, 6'h04, 6'h00, 0, 1, 4'd1, O_DEC);
    add("b0_ex",  0, 6'h04, 6'h00, 0, 1, 4'd8, O_BEQ0);
    // SW with three stall cycles in MEMWR
    add("sw_f",   0, 6'h2B, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("sw_d",   0, 6'h2B, 6'h00, 0, 1, 4'd1, O_DEC);
    add("sw_a",   0, 6'h2B, 6'h00, 0, 0, 4'd2, O_MADR);
    add("sw_w0",  0, 6'h2B, 6'h00, 1, 0, 4'd5, O_MWRS);
    add("sw_w1",  0, 6'h2B, 6'h00, 1, 0, 4'd5, O_MWRS);
    add("sw_w2",  0, 6'h2B, 6'h00, 1, 0, 4'd5, O_MWRS);
    add("sw_w3",  0, 6'h2B, 6'h00, 0, 1, 4'd5, O_MWR);
    // ADDI, J
    add("ad_f",   0, 6'h08, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("ad_d",   0, 6'h08, 6'h00, 0, 1, 4'd1, O_DEC);
    add("ad_ex",  0, 6'h08, 6'h00, 1, 1, 4'd9, O_AEX);
    add("ad_wb",  0, 6'h08, 6'h00, 0, 1, 4'd10, O_AWB);
    add("j_f",    0, 6'h02, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("j_d",    0, 6'h02, 6'h00, 0, 1, 4'd1, O_DEC);
    add("j_ex",   0, 6'h02, 6'h00, 0, 1, 4'd11, O_JEX);
    // illegal opcode trap, sticky, cleared only by reset
    add("il_f",   0, 6'h3F, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("il_d",   0, 6'h3F, 6'h00, 0, 1, 4'd1, O_DEC);
    for (int i = 0; i < 10; i++)
      add($sformatf("il_trap%0d", i), 0, 6'h3F, 6'h00, i[0], i[1], 4'd12, O_TRAP);
    add("il_rst", 1, 6'h3F, 6'h00, 0, 1, 4'd0, O_ZERO);
    // illegal funct trap
    add("bf_f",   0, 6'h00, 6'h3F, 0, 1, 4'd0, O_FETCH);
    add("bf_d",   0, 6'h00, 6'h3F, 0, 1, 4'd1, O_DEC);
    add("bf_ex",  0, 6'h00, 6'h3F, 0, 1, 4'd6, O_REX_BAD);
    add("bf_trap",0, 6'h00, 6'h3F, 0, 1, 4'd12, O_TRAP);
    add("bf_rst", 1, 6'h23, 6'h00, 0, 1, 4'd0, O_ZERO);
    // reset during a stalled MEMRD abandons the load
    add("rl_f",   0, 6'h23, 6'h00, 0, 1, 4'd0, O_FETCH);
    add("rl_d",   0, 6'h23, 6'h00, 0, 1, 4'd1, O_DEC);
    add("rl_a",   0, 6'h23, 6'h00, 0, 1, 4'd2, O_MADR);
    add("rl_rs",  0, 6'h23, 6'h00, 0, 0, 4'd3, O_MRD);
    add("rl_rst", 1, 6'h23, 6'h00, 0, 1, 4'd0, O_ZERO);
    add("rl_f2",  0, 6'h23, 6'h00, 0, 1, 4'd0, O_FETCH);

    foreach (vecs[i]) begin
      @(negedge CLK);
      RST = vecs[i].rst; OP = vecs[i].op; FUNCT = vecs[i].funct;
      ZERO = vecs[i].zero; MEM_READY = vecs[i].ready;
      #1;
      chk({vecs[i].name, "_state"}, STATE, vecs[i].exp_state);
      chk({vecs[i].name, "_outs"}, outs(), vecs[i].exp_out);
    end

    measure("lat_lw",   6'h23, 6'h00, 5);
    measure("lat_sw",   6'h2B, 6'h00, 4);
    measure("lat_r",    6'h00, 6'h20, 4);
    measure("lat_addi", 6'h08, 6'h00, 4);
    measure("lat_beq",  6'h04, 6'h00, 3);
    measure("lat_j",    6'h02, 6'h00, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
